id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 185 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, flush squashing and a
// halt drain sequencer (RUN -> DRAIN -> HALTED).
module id_ex_stage #(
    parameter int DATA_W       = 32,
    parameter int PC_W         = 9,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_ALUSrc,
    input  logic              id_MemtoReg,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_Branch,
    input  logic              id_halt,
    input  logic [1:0]        id_ALUOp,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              ex_valid,
    output logic              ex_ALUSrc,
    output logic              ex_MemtoReg,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_Branch,
    output logic              ex_halt,
    output logic [1:0]        ex_ALUOp,
    output logic [PC_W-1:0]   ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              stall_o,
    output logic              halted,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES) + 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              ALUSrc;
        logic              MemtoReg;
        logic              RegWrite;
        logic              MemRead;
        logic              MemWrite;
        logic              Branch;
        logic              halt;
        logic [1:0]        ALUOp;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
    } ex_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ex_t              ex_q, ex_d;
    logic             do_load, do_bubble, hazard;

    // Handshake: ID offers an instruction with id_valid; it is consumed on any
    // non-hold edge where stall_o is low, otherwise ID must present it again.
    assign hazard = ex_q.valid & ex_q.MemRead & (ex_q.rd != 5'd0) & id_valid &
                    ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
    assign stall_o = hazard & (state_q == RUN) & ~flush_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_load   = 1'b0;
        do_bubble = 1'b0;
        if (!hold_i) begin
            unique case (state_q)
                RUN: begin
                    if (flush_i || stall_o) begin
                        do_bubble = 1'b1;
                    end else begin
                        do_load = 1'b1;
                        if (id_valid && id_halt) begin
                            state_d = DRAIN;
                            cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                        end
                    end
                end
                DRAIN: begin
                    do_bubble = 1'b1;
                    if (cnt_q == '0) state_d = HALTED;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                HALTED: do_bubble = 1'b1;
                default: begin
                    do_bubble = 1'b1;
                    state_d   = RUN;
                end
            endcase
        end
    end

    // Data fields follow ID on every load; controls only survive with a valid instruction.
    always_comb begin
        ex_d = ex_q;
        if (do_load) begin
            ex_d.valid    = id_valid;
            ex_d.ALUSrc   = id_ALUSrc & id_valid;
            ex_d.MemtoReg = id_MemtoReg & id_valid;
            ex_d.RegWrite = id_RegWrite & id_valid;
            ex_d.MemRead  = id_MemRead & id_valid;
            ex_d.MemWrite = id_MemWrite & id_valid;
            ex_d.Branch   = id_Branch & id_valid;
            ex_d.halt     = id_halt & id_valid;
            ex_d.ALUOp    = id_ALUOp & {2{id_valid}};
            ex_d.pc       = id_pc;
            ex_d.rd1      = id_rd1;
            ex_d.rd2      = id_rd2;
            ex_d.imm      = id_imm;
            ex_d.rs1      = id_rs1;
            ex_d.rs2      = id_rs2;
            ex_d.rd       = id_rd;
            ex_d.funct3   = id_funct3;
            ex_d.funct7   = id_funct7;
        end else if (do_bubble) begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_ALUSrc   = ex_q.ALUSrc;
    assign ex_MemtoReg = ex_q.MemtoReg;
    assign ex_RegWrite = ex_q.RegWrite;
    assign ex_MemRead  = ex_q.MemRead;
    assign ex_MemWrite = ex_q.MemWrite;
    assign ex_Branch   = ex_q.Branch;
    assign ex_halt     = ex_q.halt;
    assign ex_ALUOp    = ex_q.ALUOp;
    assign ex_pc       = ex_q.pc;
    assign ex_rd1      = ex_q.rd1;
    assign ex_rd2      = ex_q.rd2;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_funct3   = ex_q.funct3;
    assign ex_funct7   = ex_q.funct7;
    assign halted      = (state_q == HALTED);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage: a cycle-level behavioural model
// pushes expectations, a monitor pops them against stall_o and the EX register.
module tb_id_ex_stage;

    localparam int DATA_W       = 32;
    localparam int PC_W         = 9;
    localparam int DRAIN_CYCLES = 3;
    localparam int OUT_W        = 1 + 7 + 2 + PC_W + 3 * DATA_W + 15 + 3 + 7 + 1;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic              id_valid, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead;
    logic              id_MemWrite, id_Branch, id_halt, hold_i, flush_i;
    logic [1:0]        id_ALUOp;
    logic [PC_W-1:0]   id_pc;
    logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic [2:0]        id_funct3;
    logic [6:0]        id_funct7;

    logic              ex_valid, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead;
    logic              ex_MemWrite, ex_Branch, ex_halt, stall_o, halted;
    logic [1:0]        ex_ALUOp, dbg_state;
    logic [PC_W-1:0]   ex_pc;
    logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [2:0]        ex_funct3;
    logic [6:0]        ex_funct7;

    id_ex_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_Branch(id_Branch),
        .id_halt(id_halt), .id_ALUOp(id_ALUOp), .id_pc(id_pc), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7(id_funct7), .hold_i(hold_i), .flush_i(flush_i),
        .ex_valid(ex_valid), .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_Branch(ex_Branch), .ex_halt(ex_halt), .ex_ALUOp(ex_ALUOp), .ex_pc(ex_pc),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .stall_o(stall_o), .halted(halted), .dbg_state(dbg_state)
    );

    logic [OUT_W-1:0] dut_vec;
    assign dut_vec = {ex_valid, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
                      ex_Branch, ex_halt, ex_ALUOp, ex_pc, ex_rd1, ex_rd2, ex_imm,
                      ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, halted};

    // reference model: EX contents plus "edges left until halted" bookkeeping
    logic              m_known = 1'b0;
    logic              m_valid = 1'b0;
    logic [6:0]        m_ctrl  = '0;   // {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, halt}
    logic [1:0]        m_aluop = '0;
    logic [PC_W-1:0]   m_pc    = '0;
    logic [DATA_W-1:0] m_rd1 = '0, m_rd2 = '0, m_imm = '0;
    logic [4:0]        m_rs1 = '0, m_rs2 = '0, m_rd = '0;
    logic [2:0]        m_f3 = '0;
    logic [6:0]        m_f7 = '0;
    logic              m_halted = 1'b0;
    int                m_drain_left = 0;

    // scoreboard
    logic [OUT_W:0] exp_q[$];
    logic [1:0]     stall_q[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic logic [OUT_W-1:0] model_vec();
        return {m_valid, m_ctrl, m_aluop, m_pc, m_rd1, m_rd2, m_imm,
                m_rs1, m_rs2, m_rd, m_f3, m_f7, m_halted};
    endfunction

    task automatic model_bubble();
        m_valid = 1'b0; m_ctrl = '0; m_aluop = '0; m_pc = '0;
        m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_f3 = '0; m_f7 = '0;
    endtask

    // Called once per cycle after inputs are applied at the falling edge.
    task automatic model_step();
        logic running, exp_stall;
        running   = (m_drain_left == 0) && !m_halted;
        exp_stall = running && !flush_i && m_valid && m_ctrl[3] && (m_rd != 5'd0) &&
                    id_valid && ((m_rd == id_rs1) || (m_rd == id_rs2));
        stall_q.push_back({m_known, exp_stall});
        if (!rst_n) begin
            model_bubble();
            m_halted = 1'b0;
            m_drain_left = 0;
            m_known = 1'b1;
        end else if (hold_i) begin
            // frozen
        end else if (!running) begin
            model_bubble();
            if (m_drain_left > 0) begin
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1'b1;
            end
        end else if (flush_i || exp_stall) begin
            model_bubble();
        end else begin
            m_valid = id_valid;
            m_ctrl  = {id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite,
                       id_Branch, id_halt} & {7{id_valid}};
            m_aluop = id_ALUOp & {2{id_valid}};
            m_pc = id_pc; m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_f3 = id_funct3; m_f7 = id_funct7;
            if (id_valid && id_halt) m_drain_left = DRAIN_CYCLES;
        end
        exp_q.push_back({m_known, model_vec()});
    endtask

    task automatic set_idle();
        rst_n = 1'b1; hold_i = 1'b0; flush_i = 1'b0; id_valid = 1'b0;
        id_ALUSrc = 1'b0; id_MemtoReg = 1'b0; id_RegWrite = 1'b0; id_MemRead = 1'b0;
        id_MemWrite = 1'b0; id_Branch = 1'b0; id_halt = 1'b0; id_ALUOp = '0;
        id_pc = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_funct3 = '0; id_funct7 = '0;
    endtask

    task automatic rand_inputs();
        rst_n       = m_halted ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 99) != 0);
        hold_i      = ($urandom_range(0, 99) < 12);
        flush_i     = ($urandom_range(0, 99) < 10);
        id_valid    = ($urandom_range(0, 99) < 85);
        id_ALUSrc   = 1'($urandom_range(0, 1));
        id_MemtoReg = 1'($urandom_range(0, 1));
        id_RegWrite = 1'($urandom_range(0, 1));
        id_MemRead  = ($urandom_range(0, 99) < 35);
        id_MemWrite = 1'($urandom_range(0, 1));
        id_Branch   = 1'($urandom_range(0, 1));
        id_halt     = ($urandom_range(0, 99) < 4);
        id_ALUOp    = 2'($urandom_range(0, 3));
        id_pc       = PC_W'($urandom);
        id_rd1      = $urandom;
        id_rd2      = $urandom;
        id_imm      = $urandom;
        id_rs1      = 5'($urandom_range(0, 7));
        id_rs2      = 5'($urandom_range(0, 7));
        id_rd       = 5'($urandom_range(0, 7));
        id_funct3   = 3'($urandom_range(0, 7));
        id_funct7   = 7'($urandom_range(0, 127));
    endtask

    // Directed cycle: inputs idle except the named overrides set by the caller.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); set_idle(); model_step();
        end
    endtask

    // monitor
    initial begin
        logic [OUT_W:0] e;
        logic [1:0]     s;
        forever begin
            @(negedge clk); #2;
            if (stall_q.size() > 0) begin
                s = stall_q.pop_front();
                if (s[1]) begin
                    n_vec++;
                    if (stall_o !== s[0]) begin
                        n_err++;
                        $display("FAIL stall_o t=%0t got=%b exp=%b", $time, stall_o, s[0]);
                    end
                end
            end
            @(posedge clk); #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e[OUT_W]) begin
                    n_vec++;
                    if (dut_vec !== e[OUT_W-1:0]) begin
                        n_err++;
                        $display("FAIL ex_regs t=%0t got=%h exp=%h", $time, dut_vec, e[OUT_W-1:0]);
                    end
                end
            end
        end
    end

    // driver
    initial begin
        set_idle();
        rst_n = 1'b0;
        repeat (2) begin @(negedge clk); set_idle(); rst_n = 1'b0; model_step(); end

        // plain load
        @(negedge clk); set_idle(); id_valid = 1'b1; id_RegWrite = 1'b1; id_rd = 5'd5;
        id_rd1 = 32'h1234; model_step();

        // load-use: lw x7 then add using x7 (stalls once), then lw x0 / add x0 (no stall)
        @(negedge clk); set_idle(); id_valid = 1'b1; id_MemRead = 1'b1; id_RegWrite = 1'b1;
        id_MemtoReg = 1'b1; id_rd = 5'd7; model_step();
        repeat (2) begin
            @(negedge clk); set_idle(); id_valid = 1'b1; id_RegWrite = 1'b1; id_ALUOp = 2'b10;
            id_rs1 = 5'd1; id_rs2 = 5'd7; id_rd = 5'd3; model_step();
        end
        @(negedge clk); set_idle(); id_valid = 1'b1; id_MemRead = 1'b1; id_rd = 5'd0; model_step();
        @(negedge clk); set_idle(); id_valid = 1'b1; id_RegWrite = 1'b1; id_rs2 = 5'd0;
        id_rd = 5'd4; model_step();

        // flush vs hold
        @(negedge clk); set_idle(); id_valid = 1'b1; id_RegWrite = 1'b1; id_rd = 5'd9;
        flush_i = 1'b1; model_step();
        @(negedge clk); set_idle(); id_valid = 1'b1; id_Branch = 1'b1; id_imm = 32'hFFFF_0010;
        model_step();
        @(negedge clk); set_idle(); id_valid = 1'b1; id_RegWrite = 1'b1; id_rd = 5'd9;
        flush_i = 1'b1; hold_i = 1'b1; model_step();

        // halt drain with one held cycle, then reset
        @(negedge clk); set_idle(); id_valid = 1'b1; id_halt = 1'b1; model_step();
        idle_cycles(1);
        @(negedge clk); set_idle(); hold_i = 1'b1; model_step();
        @(negedge clk); set_idle(); flush_i = 1'b1; model_step();
        idle_cycles(4);
        @(negedge clk); set_idle(); rst_n = 1'b0; model_step();

        // halt squashed by flush
        @(negedge clk); set_idle(); id_valid = 1'b1; id_halt = 1'b1; flush_i = 1'b1; model_step();
        idle_cycles(5);

        // reset mid-drain, then a normal load
        @(negedge clk); set_idle(); id_valid = 1'b1; id_halt = 1'b1; model_step();
        idle_cycles(1);
        @(negedge clk); set_idle(); rst_n = 1'b0; hold_i = 1'b1; model_step();
        @(negedge clk); set_idle(); id_valid = 1'b1; id_RegWrite = 1'b1; id_rd = 5'd12;
        id_pc = 9'h1A5; model_step();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); rand_inputs(); model_step();
        end

        @(negedge clk); set_idle();
        repeat (3) @(posedge clk);
        #3;
        n_vec++;
        if (exp_q.size() != 0 || stall_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_queues got=%0d/%0d pending exp=0/0", exp_q.size(), stall_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
